// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   // Controller states: waiting, adding one bit per clock, presenting a result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the bit-slice of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   // Sum and carry of one bit position; carry uses the propagate/generate form
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, added LSB-first through a
// single full-adder over WIDTH cycles, and the result is held in output
// registers that only change when a new result is complete.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] aShift_q, aShift_d;
   logic [WIDTH-1:0] bShift_q, bShift_d;
   logic [WIDTH-1:0] partSum_q, partSum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             faSum, faCarry;

   full_adder bitSlice (
      .a   (aShift_q[0]),
      .b   (bShift_q[0]),
      .cin (carry_q),
      .s   (faSum),
      .co  (faCarry)
   );

   // State, datapath and result registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         aShift_q  <= '0;
         bShift_q  <= '0;
         partSum_q <= '0;
         carry_q   <= 1'b0;
         count_q   <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         aShift_q  <= aShift_d;
         bShift_q  <= bShift_d;
         partSum_q <= partSum_d;
         carry_q   <= carry_d;
         count_q   <= count_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   // Next-state and datapath control; DONE accepts a new start like IDLE so
   // back-to-back operations run without a bubble
   always_comb begin
      state_d   = state_q;
      aShift_d  = aShift_q;
      bShift_d  = bShift_q;
      partSum_d = partSum_q;
      carry_d   = carry_q;
      count_d   = count_q;
      sum_d     = sum_q;
      cout_d    = cout_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               aShift_d  = a;
               bShift_d  = b;
               partSum_d = '0;
               carry_d   = cin;
               count_d   = '0;
               state_d   = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            aShift_d  = aShift_q >> 1;
            bShift_d  = bShift_q >> 1;
            partSum_d = {faSum, partSum_q[WIDTH-1:1]};
            carry_d   = faCarry;
            count_d   = count_q + CNT_W'(1);
            if (count_q == LAST_BIT) begin
               sum_d   = {faSum, partSum_q[WIDTH-1:1]};
               cout_d  = faCarry;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a cycle-level reference model of the
// 8-bit instance checked every cycle, directed vectors with literal results,
// and random sweeps on an 8-bit and a 16-bit instance.
module tb_serial_adder;

   localparam int W8  = 8;
   localparam int W16 = 16;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start8;
   logic [7:0]  a8, b8;
   logic        cin8;
   logic [7:0]  sum8;
   logic        cout8, busy8, done8;

   logic        start16;
   logic [15:0] a16, b16;
   logic        cin16;
   logic [15:0] sum16;
   logic        cout16, busy16, done16;

   int vecCount  = 0;
   int failCount = 0;
   bit checkEn   = 1'b0;

   serial_adder #(.WIDTH(W8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .sum   (sum8),
      .cout  (cout8),
      .busy  (busy8),
      .done  (done8)
   );

   serial_adder #(.WIDTH(W16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start16),
      .a     (a16),
      .b     (b16),
      .cin   (cin16),
      .sum   (sum16),
      .cout  (cout16),
      .busy  (busy16),
      .done  (done16)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // Reference model: an accepted request is busy for WIDTH cycles, then its
   // arithmetic sum appears together with a single-cycle done
   int         mLeft    = 0;
   logic       mDone    = 1'b0;
   logic [7:0] mSum     = 8'h00;
   logic       mCout    = 1'b0;
   logic [8:0] mPending = 9'h000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mLeft = 0;
         mDone = 1'b0;
         mSum  = 8'h00;
         mCout = 1'b0;
      end else if (mLeft > 0) begin
         mLeft = mLeft - 1;
         if (mLeft == 0) begin
            mDone = 1'b1;
            {mCout, mSum} = mPending;
         end
      end else begin
         mDone = 1'b0;
         if (start8) begin
            mPending = 9'(a8) + 9'(b8) + 9'(cin8);
            mLeft    = W8;
         end
      end
   end

   // Per-cycle comparison of the 8-bit DUT against the model, away from the clock edge
   always @(negedge clk) begin
      if (checkEn) begin
         vecCount++;
         if (busy8 !== (mLeft > 0) || done8 !== mDone || sum8 !== mSum || cout8 !== mCout) begin
            failCount++;
            $display("[TB] FAIL cycle t=%0t: got busy=%0b done=%0b sum=%02h cout=%0b, expected busy=%0b done=%0b sum=%02h cout=%0b",
                     $time, busy8, done8, sum8, cout8, (mLeft > 0), mDone, mSum, mCout);
         end
      end
   end

   // One literal comparison with a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Waits (bounded) for done8 starting at the current negedge, counting negedges
   task automatic waitDone8(input int limit, output int n);
      n = 0;
      while (!done8 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!done8) checkOutput("done8 timeout", 32'(done8), 32'd1);
   endtask

   // Issues one 8-bit request and waits for its done; reports latency and busy cycles
   task automatic applyStimulus8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                                 output int lat, output int busyN);
      @(negedge clk);
      a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat   = 1;
      busyN = busy8 ? 1 : 0;
      while (!done8 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy8) busyN++;
      end
      checkOutput("latency8", 32'(lat), 32'd9);
   endtask

   // Issues one 16-bit request, waits for done, checks the arithmetic result
   task automatic applyStimulus16(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
      int lat;
      logic [16:0] expect17;
      expect17 = 17'(ia) + 17'(ib) + 17'(ic);
      @(negedge clk);
      a16 = ia; b16 = ib; cin16 = ic; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (!done16 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("latency16", 32'(lat), 32'd17);
      checkOutput("result16", 32'({cout16, sum16}), 32'(expect17));
   endtask

   // Directed scenarios followed by random sweeps
   initial begin
      int lat, busyN, n, doneSeen;
      logic [7:0]  ra, rb;
      logic [15:0] wa, wb;
      logic        rc;

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset sum", 32'(sum8), 32'h0);
      checkOutput("reset cout", 32'(cout8), 32'h0);
      checkOutput("reset busy", 32'(busy8), 32'h0);
      checkOutput("reset done", 32'(done8), 32'h0);
      rst_n = 1'b1;
      checkEn = 1'b1;

      // Basic addition, busy width and done pulse width
      applyStimulus8(8'h3C, 8'h05, 1'b0, lat, busyN);
      checkOutput("t1 sum", 32'(sum8), 32'h41);
      checkOutput("t1 cout", 32'(cout8), 32'h0);
      checkOutput("t1 busy cycles", 32'(busyN), 32'd8);
      @(negedge clk);
      checkOutput("t1 done one cycle", 32'(done8), 32'h0);

      // Carry-out boundaries
      applyStimulus8(8'hFF, 8'h01, 1'b0, lat, busyN);
      checkOutput("t2 sum", 32'(sum8), 32'h00);
      checkOutput("t2 cout", 32'(cout8), 32'h1);
      applyStimulus8(8'hFF, 8'hFF, 1'b1, lat, busyN);
      checkOutput("t3 sum", 32'(sum8), 32'hFF);
      checkOutput("t3 cout", 32'(cout8), 32'h1);

      // A start during SHIFT must be ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      waitDone8(40, n);
      checkOutput("t4 sum", 32'(sum8), 32'h30);
      checkOutput("t4 cout", 32'(cout8), 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("t4 sum held", 32'(sum8), 32'h30);
      checkOutput("t4 idle busy", 32'(busy8), 32'h0);

      // Asynchronous reset in the middle of SHIFT
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5 reset sum", 32'(sum8), 32'h0);
      checkOutput("t5 reset cout", 32'(cout8), 32'h0);
      checkOutput("t5 reset busy", 32'(busy8), 32'h0);
      checkOutput("t5 reset done", 32'(done8), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) doneSeen++;
      end
      checkOutput("t5 no done after reset", 32'(doneSeen), 32'd0);
      applyStimulus8(8'h01, 8'h02, 1'b0, lat, busyN);
      checkOutput("t5 next sum", 32'(sum8), 32'h03);

      // Back-to-back with start held high
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h01;
      waitDone8(40, n);
      checkOutput("t6 first sum", 32'(sum8), 32'h02);
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("t6 no bubble", 32'(busy8), 32'h1);
      waitDone8(40, n);
      checkOutput("t6 period", 32'(n + 1), 32'd9);
      checkOutput("t6 second sum", 32'(sum8), 32'h80);
      checkOutput("t6 second cout", 32'(cout8), 32'h0);

      // Random sweep, 8-bit
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         applyStimulus8(ra, rb, rc, lat, busyN);
         checkOutput("rand8 result", 32'({cout8, sum8}), 32'(9'(ra) + 9'(rb) + 9'(rc)));
      end

      // Random sweep, 16-bit
      for (int i = 0; i < 1000; i++) begin
         wa = 16'($urandom);
         wb = 16'($urandom);
         rc = 1'($urandom);
         applyStimulus16(wa, wb, rc);
      end

      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
